// File: rtl/risc8_mem_pkg.sv
// Shared constants for the risc8 data-memory path: bus widths and the
// bit positions of the read-owner tag.
package risc8_mem_pkg;
  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned OWNER_CPU = 0;
  localparam int unsigned OWNER_DMA = 1;
endpackage

// File: rtl/risc8_prio_starve.sv
// Two-input fixed-priority arbiter. The low-priority side is force-granted
// for one cycle after MAX_WAIT consecutive refusals.
module risc8_prio_starve #(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned CNT_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_hi,
  input  logic             req_lo,
  output logic             gnt_hi,
  output logic             gnt_lo,
  output logic [CNT_W-1:0] wait_cnt
);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             force_lo;

  always_comb begin
    force_lo   = req_lo && (wait_cnt_q == MAX_CNT);
    // Both grants are held low while reset is asserted.
    gnt_lo     = !reset && req_lo && (!req_hi || force_lo);
    gnt_hi     = !reset && req_hi && !gnt_lo;
    wait_cnt_d = wait_cnt_q;
    if (!req_lo || gnt_lo) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != MAX_CNT) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign wait_cnt = wait_cnt_q;
endmodule

// File: rtl/risc8_ram_arbiter.sv
// Shares the single-port risc8 data RAM between the CPU (priority) and the
// DMA/boot-copy engine. Handshake: an access happens in the cycle where req and gnt are both 1.
module risc8_ram_arbiter
  import risc8_mem_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned CNT_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_wen,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  logic [CNT_W-1:0] wait_cnt;
  logic [1:0]       rd_owner_q, rd_owner_d;

  risc8_prio_starve #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) u_prio (
    .clk      (clk),
    .reset    (reset),
    .req_hi   (cpu_req),
    .req_lo   (dma_req),
    .gnt_hi   (cpu_gnt),
    .gnt_lo   (dma_gnt),
    .wait_cnt (wait_cnt)
  );

  always_comb begin
    ram_addr  = dma_gnt ? dma_addr  : cpu_addr;
    ram_wdata = dma_gnt ? dma_wdata : cpu_wdata;
    ram_wen   = (cpu_gnt && cpu_wen) || (dma_gnt && dma_wen);
    rd_owner_d            = '0;
    rd_owner_d[OWNER_CPU] = cpu_gnt && !cpu_wen;
    rd_owner_d[OWNER_DMA] = dma_gnt && !dma_wen;
  end

  // The owner tag lines up with the RAM's one-cycle read latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_owner_q <= '0;
    end else begin
      rd_owner_q <= rd_owner_d;
    end
  end

  assign cpu_rvalid = rd_owner_q[OWNER_CPU];
  assign dma_rvalid = rd_owner_q[OWNER_DMA];
  assign cpu_rdata  = ram_rdata;
  assign dma_rdata  = ram_rdata;
endmodule

// File: tb/tb_risc8_ram_arbiter.sv
// Bench for risc8_ram_arbiter: a behavioural RAM behind the arbiter and a
// reference model of grants, memory contents and pending reads.
module tb_risc8_ram_arbiter;
  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_wen = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        dma_req = 1'b0, dma_wen = 1'b0;
  logic [15:0] dma_addr = '0;
  logic [7:0]  dma_wdata = '0;
  logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, ram_wen;
  logic [7:0]  cpu_rdata, dma_rdata, ram_wdata;
  logic [7:0]  ram_rdata = '0;
  logic [15:0] ram_addr;

  risc8_ram_arbiter #(.MAX_WAIT(MAX_WAIT), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_wen(dma_wen), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Clock and behavioural single-port RAM with 1-cycle read latency.
  always #5 clk = ~clk;

  logic [7:0] ram_mem [0:65535];
  logic [7:0] shadow  [0:65535];

  always @(posedge clk) begin
    logic [7:0] rd;
    rd = ram_mem[ram_addr];
    if (ram_wen) ram_mem[ram_addr] = ram_wdata;
    ram_rdata <= rd;
  end

  // Reference model state.
  int         n_vec = 0;
  int         n_err = 0;
  int         m_cnt = 0;
  logic       m_cv = 1'b0, m_dv = 1'b0;
  logic [7:0] m_cd = '0, m_dd = '0;
  logic       last_cg, last_dg;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive after the edge, check at the falling edge, advance the model.
  task automatic step(input logic r,
                      input logic cr, input logic cw, input logic [15:0] ca, input logic [7:0] cd,
                      input logic dr, input logic dw, input logic [15:0] da, input logic [7:0] dd);
    logic eg_c, eg_d;
    @(posedge clk); #1;
    reset = r;
    cpu_req = cr; cpu_wen = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dr; dma_wen = dw; dma_addr = da; dma_wdata = dd;
    eg_d = !r && dr && (!cr || m_cnt == MAX_WAIT);
    eg_c = !r && cr && !eg_d;
    @(negedge clk);
    chk("cpu_gnt", 16'(cpu_gnt), 16'(eg_c));
    chk("dma_gnt", 16'(dma_gnt), 16'(eg_d));
    chk("ram_wen", 16'(ram_wen), 16'((eg_c && cw) || (eg_d && dw)));
    chk("ram_addr", ram_addr, eg_d ? da : ca);
    if ((eg_c && cw) || (eg_d && dw)) chk("ram_wdata", 16'(ram_wdata), 16'(eg_d ? dd : cd));
    chk("cpu_rvalid", 16'(cpu_rvalid), 16'(!r && m_cv));
    chk("dma_rvalid", 16'(dma_rvalid), 16'(!r && m_dv));
    if (!r && m_cv) chk("cpu_rdata", 16'(cpu_rdata), 16'(m_cd));
    if (!r && m_dv) chk("dma_rdata", 16'(dma_rdata), 16'(m_dd));
    last_cg = eg_c;
    last_dg = eg_d;
    if (r) begin
      m_cnt = 0; m_cv = 1'b0; m_dv = 1'b0;
    end else begin
      m_cv = eg_c && !cw; m_cd = shadow[ca];
      m_dv = eg_d && !dw; m_dd = shadow[da];
      if (eg_c && cw) shadow[ca] = cd;
      if (eg_d && dw) shadow[da] = dd;
      if (dr && !eg_d) m_cnt = (m_cnt < MAX_WAIT) ? m_cnt + 1 : m_cnt;
      else m_cnt = 0;
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0);
  endtask

  initial begin
    logic [7:0]  pre_1234;
    logic        c_pend, c_w, d_pend, d_w;
    logic [15:0] c_a, d_a;
    logic [7:0]  c_d, d_d;

    for (int i = 0; i < 65536; i++) begin
      ram_mem[i] = 8'($urandom);
      shadow[i]  = ram_mem[i];
    end
    pre_1234 = shadow[16'h1234];

    // Reset held with both sides requesting writes.
    step(1'b1, 1'b1, 1'b1, 16'h1234, 8'hEE, 1'b1, 1'b1, 16'h1234, 8'hDD);
    step(1'b1, 1'b1, 1'b1, 16'h1234, 8'hEE, 1'b1, 1'b1, 16'h1234, 8'hDD);
    step(1'b0, 1'b1, 1'b0, 16'h1234, 8'h00, 1'b0, 1'b0, 16'h0, 8'h0);
    idle();
    chk("pre_reset_contents", 16'(cpu_rdata), 16'(pre_1234));

    // CPU only: write then read back.
    step(1'b0, 1'b1, 1'b1, 16'h8001, 8'hA5, 1'b0, 1'b0, 16'h0, 8'h0);
    step(1'b0, 1'b1, 1'b0, 16'h8001, 8'h00, 1'b0, 1'b0, 16'h0, 8'h0);
    idle();
    chk("cpu_raw_data", 16'(cpu_rdata), 16'h00A5);

    // DMA only: preload 0x10..0x13, then read back-to-back.
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 1'b1, 16'(i), 8'(8'h10 + i));
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 1'b0, 16'(i), 8'h0);
      if (i > 0) chk("dma_seq_data", 16'(dma_rdata), 16'(8'h10 + i - 1));
    end
    idle();
    chk("dma_seq_last", 16'(dma_rdata), 16'h0013);

    // Starvation: both requesting for 15 cycles, DMA every fifth.
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b1, 1'b0, 16'(16'h2000 + i), 8'h0, 1'b1, 1'b0, 16'h3000, 8'h0);
      chk("starve_pattern", 16'(dma_gnt), 16'(i % 5 == 4));
    end
    idle();

    // Contention: DMA force-granted write to 0x7FFF while CPU reads it.
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 1'b0, 16'(16'h4000 + i), 8'h0, 1'b1, 1'b1, 16'h7FFF, 8'h3C);
    step(1'b0, 1'b1, 1'b0, 16'h7FFF, 8'h0, 1'b1, 1'b1, 16'h7FFF, 8'h3C);
    chk("force_write", 16'(dma_gnt), 16'h0001);
    step(1'b0, 1'b1, 1'b0, 16'h7FFF, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0);
    idle();
    chk("contention_read", 16'(cpu_rdata), 16'h003C);

    // Reset the cycle after a granted CPU read.
    step(1'b0, 1'b1, 1'b0, 16'h8001, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0);
    step(1'b1, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0);
    idle();
    idle();

    // Randomized traffic; requesters hold their request until granted or cancel.
    c_pend = 1'b0; d_pend = 1'b0;
    c_w = 1'b0; d_w = 1'b0; c_a = '0; d_a = '0; c_d = '0; d_d = '0;
    for (int i = 0; i < 400; i++) begin
      if (!c_pend && $urandom_range(0, 3) != 0) begin
        c_pend = 1'b1; c_w = 1'($urandom_range(0, 1));
        c_a = 16'($urandom_range(16'h0100, 16'h0107)); c_d = 8'($urandom);
      end else if (c_pend && $urandom_range(0, 31) == 0) begin
        c_pend = 1'b0;
      end
      if (!d_pend && $urandom_range(0, 2) != 0) begin
        d_pend = 1'b1; d_w = 1'($urandom_range(0, 1));
        d_a = 16'($urandom_range(16'h0100, 16'h0107)); d_d = 8'($urandom);
      end else if (d_pend && $urandom_range(0, 31) == 0) begin
        d_pend = 1'b0;
      end
      step(1'b0, c_pend, c_w, c_a, c_d, d_pend, d_w, d_a, d_d);
      if (last_cg) c_pend = 1'b0;
      if (last_dg) d_pend = 1'b0;
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/risc8_ram_arbiter.md
Name: risc8_ram_arbiter

Overview:
Two-port arbiter that shares the single-port 64 KB risc8 data RAM between the CPU and a DMA/boot-copy engine. The boot-copy engine is needed because the SPRAM-backed build cannot be preloaded from the bitstream. The block sits directly in front of risc8_ram, which has a 1-cycle read latency.
- CPU has fixed priority.
- A wait counter guarantees DMA forward progress.
- A registered owner tag steers read data back to the requester that issued the read.

Parameters:
- MAX_WAIT, 4: consecutive cycles DMA may be refused before it is force-granted one cycle (legal range 1..15).
- CNT_W, 4: width of the wait counter; must hold MAX_WAIT.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU requests an access this cycle
- cpu_wen  in  1  1 = write, 0 = read
- cpu_addr  in  16  CPU byte address
- cpu_wdata  in  8  CPU write data
- cpu_gnt  out  1  CPU access accepted this cycle (combinational)
- cpu_rvalid  out  1  cpu_rdata valid (cycle after a granted CPU read)
- cpu_rdata  out  8  read data to CPU
- dma_req, dma_wen, dma_addr[15:0], dma_wdata[7:0]  in  DMA request, same meaning as the CPU inputs
- dma_gnt  out  1  DMA access accepted this cycle
- dma_rvalid  out  1  dma_rdata valid
- dma_rdata  out  8  read data to DMA
- ram_wen  out  1  to risc8_ram wen
- ram_addr  out  16  to risc8_ram addr
- ram_wdata  out  8  to risc8_ram wdata
- ram_rdata  in  8  from risc8_ram rdata

Behaviour:
- Grant is combinational from the request lines and the registered wait count.
  - force = dma_req & (wait_cnt == MAX_WAIT)
  - dma_gnt = dma_req & (!cpu_req | force)
  - cpu_gnt = cpu_req & !dma_gnt
  - At most one grant per cycle; both grants are 0 while reset is asserted.
- RAM mux:
  - If dma_gnt, drive the DMA addr/wdata; otherwise drive the CPU addr/wdata, including when idle.
  - ram_wen = (cpu_gnt & cpu_wen) | (dma_gnt & dma_wen); never 1 without a grant.
- Wait counter:
  - Increments when dma_req & !dma_gnt.
  - Clears when dma_gnt or !dma_req.
  - Saturates at MAX_WAIT.
  - Reset value 0.
- Read return (registered):
  - rd_owner[1:0] <= {dma_gnt & !dma_wen, cpu_gnt & !cpu_wen}.
  - cpu_rvalid = rd_owner[0]; dma_rvalid = rd_owner[1].
  - Both rdata outputs are ram_rdata passed through combinationally. Consumers must qualify with rvalid.
- Latency: grant in cycle N, read data and rvalid in cycle N+1. Writes complete at the edge ending cycle N.
- Throughput: one access per cycle, back-to-back grants allowed. Read-after-write to the same address in consecutive cycles returns the new data.
- Requesters must hold req, addr, wen and wdata stable until they see gnt. Deasserting req without a grant is allowed and cancels the request.
- Reset values: cpu_gnt=0, dma_gnt=0, cpu_rvalid=0, dma_rvalid=0, ram_wen=0, wait_cnt=0, rd_owner=0.
- Reset asserted mid-read: the pending rvalid is dropped and no rvalid is produced after reset release.
- Both requesting continuously: the pattern is MAX_WAIT CPU grants followed by 1 DMA grant, repeating.

Decomposition:
- Shared package: risc8_mem_pkg with constants ADDR_W=16, DATA_W=8, OWNER_CPU=0, OWNER_DMA=1.
- No sub-module required. The grant/wait logic may optionally be split out as risc8_prio_starve (2-input fixed-priority arbiter with starvation counter), reusable for a future I/O bus arbiter.

Test Plan:
1. Reset held, both req=1 with wen=1 -> gnt=0, ram_wen=0. After reset release, read 0x1234 returns its pre-reset contents (no write occurred).
2. CPU only: write 0xA5 to 0x8001, then read 0x8001 next cycle -> cpu_gnt=1 both cycles; cpu_rvalid=1 in the following cycle with cpu_rdata=0xA5; dma_rvalid stays 0.
3. DMA only: reads 0x0000..0x0003 back-to-back after preloading 0x10..0x13 -> dma_rvalid=1 for 4 consecutive cycles with data 0x10, 0x11, 0x12, 0x13.
4. Starvation, MAX_WAIT=4, both req=1 for 15 cycles -> grant pattern C,C,C,C,D,C,C,C,C,D,C,C,C,C,D; wait_cnt never exceeds 4.
5. Contention on one address: CPU reads 0x7FFF in the same cycle DMA is force-granted a write of 0x3C to 0x7FFF -> DMA write lands; CPU is granted the next cycle and reads 0x3C.
6. Reset asserted the cycle after a granted CPU read -> cpu_rvalid=0 immediately and stays 0 after reset release until a new grant.
